// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings for the control pipe: opcodes, mux selects and the
// per-stage control word carried from E down to the last stage.
package ctrl_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    PC_ADD4 = 2'b00,
    PC_NPC  = 2'b01,
    PC_RD1  = 2'b10
  } pc_sel_t;

  typedef enum logic [2:0] {
    NPC_NONE = 3'b000,
    NPC_BEQ  = 3'b001,
    NPC_JAL  = 3'b010,
    NPC_JR   = 3'b011,
    NPC_J    = 3'b100
  } npc_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_OR  = 2'b10,
    ALU_LUI = 2'b11
  } alu_op_t;

  // One entry of the stage shift register; all-zero is a bubble.
  typedef struct packed {
    logic       regwr;
    logic [4:0] a3;
    logic       memrd;
    logic       memwr;
    alu_op_t    alu_op;
  } ctrl_word_t;

  typedef struct packed {
    ctrl_word_t cw;
    npc_sel_t   npc_sel;
    logic       ext_op;
    logic       is_beq;
    logic       is_jr;
    logic       is_jmp;
    logic       reads_rs;
    logic       reads_rt;
    logic       illegal;
  } dec_t;

  function automatic logic reads_reg(dec_t d, logic [4:0] rs, logic [4:0] rt,
                                     logic [4:0] a3);
    return (d.reads_rs && rs == a3) || (d.reads_rt && rt == a3);
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// D-stage instruction fields in, pipeline control out.
interface ctrl_pipe_if #(parameter int STAGES = 3);
  logic                  d_valid;
  logic [5:0]            op;
  logic [5:0]            func;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic                  zero;
  logic                  stall;
  logic                  flush_f;
  logic [1:0]            pc_sel;
  logic [2:0]            npc_sel;
  logic                  ext_op;
  logic [1:0]            alu_op_e;
  logic [STAGES-1:0]     regwr;
  logic [5*STAGES-1:0]   a3;
  logic [STAGES-1:0]     memrd;
  logic [STAGES-1:0]     memwr;
  logic                  illegal;

  modport master (
    output d_valid, op, func, rs, rt, rd, zero,
    input  stall, flush_f, pc_sel, npc_sel, ext_op, alu_op_e,
           regwr, a3, memrd, memwr, illegal
  );

  modport slave (
    input  d_valid, op, func, rs, rt, rd, zero,
    output stall, flush_f, pc_sel, npc_sel, ext_op, alu_op_e,
           regwr, a3, memrd, memwr, illegal
  );
endinterface

// File: rtl/ctrl_pipe_decode.sv
// Pure combinational op/func decoder; unknown encodings come out as a
// zero control word with the illegal flag set.
module ctrl_decode
  import ctrl_pipe_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  output dec_t       dec_o
);

  logic [4:0] dst;
  logic       wr;

  always_comb begin
    dec_o = '0;
    dst   = '0;
    wr    = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADDU: begin
            wr = 1'b1; dst = rd_i;
            dec_o.reads_rs = 1'b1; dec_o.reads_rt = 1'b1;
          end
          FN_SUBU: begin
            wr = 1'b1; dst = rd_i; dec_o.cw.alu_op = ALU_SUB;
            dec_o.reads_rs = 1'b1; dec_o.reads_rt = 1'b1;
          end
          FN_JR: begin
            dec_o.is_jr = 1'b1; dec_o.reads_rs = 1'b1; dec_o.npc_sel = NPC_JR;
          end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OP_ORI: begin
        wr = 1'b1; dst = rt_i; dec_o.cw.alu_op = ALU_OR; dec_o.reads_rs = 1'b1;
      end
      OP_LUI: begin
        wr = 1'b1; dst = rt_i; dec_o.cw.alu_op = ALU_LUI;
      end
      OP_LW: begin
        wr = 1'b1; dst = rt_i; dec_o.cw.memrd = 1'b1;
        dec_o.ext_op = 1'b1; dec_o.reads_rs = 1'b1;
      end
      OP_SW: begin
        dec_o.cw.memwr = 1'b1; dec_o.ext_op = 1'b1;
        dec_o.reads_rs = 1'b1; dec_o.reads_rt = 1'b1;
      end
      OP_BEQ: begin
        dec_o.is_beq = 1'b1; dec_o.npc_sel = NPC_BEQ; dec_o.cw.alu_op = ALU_SUB;
        dec_o.reads_rs = 1'b1; dec_o.reads_rt = 1'b1;
      end
      OP_J:    begin dec_o.is_jmp = 1'b1; dec_o.npc_sel = NPC_J; end
      OP_JAL:  begin dec_o.is_jmp = 1'b1; dec_o.npc_sel = NPC_JAL; wr = 1'b1; dst = REG_RA; end
      default: dec_o.illegal = 1'b1;
    endcase
    dec_o.cw.a3    = dst;
    dec_o.cw.regwr = wr && (dst != '0);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Hazard detection, PC select and the E..last control-word shift register
// around the instruction decoder.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int DELAY_SLOT = 1
)(
  input  logic        clk,
  input  logic        rst_n,
  ctrl_pipe_if.slave  bus
);

  dec_t                    dec;
  ctrl_word_t [STAGES-1:0] stg_q, stg_d;
  logic                    illegal_q, illegal_d;
  logic                    live, lu_haz, br_haz, stall;
  pc_sel_t                 pc_sel;
  npc_sel_t                npc_sel;

  ctrl_decode u_dec (
    .op_i   (bus.op),
    .func_i (bus.func),
    .rt_i   (bus.rt),
    .rd_i   (bus.rd),
    .dec_o  (dec)
  );

  // Branches resolve in D, so they also wait on any pending ALU result in E
  // and on a load still in M; other consumers only wait on a load in E.
  always_comb begin
    live    = rst_n && bus.d_valid;
    lu_haz  = stg_q[0].memrd && (stg_q[0].a3 != '0) &&
              reads_reg(dec, bus.rs, bus.rt, stg_q[0].a3);
    br_haz  = (dec.is_beq || dec.is_jr) &&
              ((stg_q[0].regwr && reads_reg(dec, bus.rs, bus.rt, stg_q[0].a3)) ||
               (stg_q[1].memrd && reads_reg(dec, bus.rs, bus.rt, stg_q[1].a3)));
    stall   = live && (lu_haz || br_haz);
    pc_sel  = PC_ADD4;
    npc_sel = NPC_NONE;
    if (live && !stall) begin
      npc_sel = dec.npc_sel;
      if ((dec.is_beq && bus.zero) || dec.is_jmp) pc_sel = PC_NPC;
      else if (dec.is_jr)                         pc_sel = PC_RD1;
    end
  end

  always_comb begin
    stg_d = '0;
    if (live && !stall) stg_d[0] = dec.cw;
    for (int k = 1; k < STAGES; k++) stg_d[k] = stg_q[k-1];
    illegal_d = live && dec.illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      stg_q     <= stg_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.stall    = stall;
  assign bus.flush_f  = (DELAY_SLOT == 0) && (pc_sel != PC_ADD4);
  assign bus.pc_sel   = pc_sel;
  assign bus.npc_sel  = npc_sel;
  assign bus.ext_op   = live && dec.ext_op;
  assign bus.alu_op_e = stg_q[0].alu_op;
  assign bus.illegal  = illegal_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_out
    assign bus.regwr[k]       = stg_q[k].regwr;
    assign bus.a3[5*k +: 5]   = stg_q[k].a3;
    assign bus.memrd[k]       = stg_q[k].memrd;
    assign bus.memwr[k]       = stg_q[k].memwr;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Drives a 3-stage delay-slot pipe and a 5-stage flushing pipe in lockstep
// and compares both against an instruction-level model of the control flow.
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.STAGES(3)) bus0();
  ctrl_pipe_if #(.STAGES(5)) bus1();

  ctrl_pipe #(.STAGES(3), .DELAY_SLOT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ctrl_pipe #(.STAGES(5), .DELAY_SLOT(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct packed {
    logic v; logic [5:0] op; logic [5:0] func;
    logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic z;
  } in_t;

  typedef struct packed {
    logic regwr; logic [4:0] a3; logic memrd; logic memwr; logic [1:0] alu;
  } mw_t;

  typedef enum {I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD} ins_e;

  typedef struct {
    in_t i; logic st; logic [1:0] pc; logic [2:0] npc; logic fl1;
    logic [4:0] ea3; logic ewr; logic ill;
  } tv_t;

  int   n_chk = 0;
  int   n_pass = 0;
  in_t  cur;
  mw_t  hist [5];     // hist[k] = expected control word in stage k
  logic ill_exp;
  bit   last_st;
  tv_t  tab [15];

  function automatic in_t mk(bit v, logic [5:0] op, logic [5:0] func,
                             logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, bit z);
    in_t r;
    r.v = v; r.op = op; r.func = func; r.rs = rs; r.rt = rt; r.rd = rd; r.z = z;
    return r;
  endfunction

  function automatic tv_t tv(in_t i, bit st, logic [1:0] pc, logic [2:0] npc, bit fl1,
                             logic [4:0] ea3, bit ewr, bit ill);
    tv_t t;
    t.i = i; t.st = st; t.pc = pc; t.npc = npc; t.fl1 = fl1;
    t.ea3 = ea3; t.ewr = ewr; t.ill = ill;
    return t;
  endfunction

  function automatic ins_e classify(in_t v);
    if (v.op == 6'h00)
      return (v.func == 6'h21) ? I_ADDU : (v.func == 6'h23) ? I_SUBU :
             (v.func == 6'h08) ? I_JR : I_BAD;
    case (v.op)
      6'h0d: return I_ORI;
      6'h0f: return I_LUI;
      6'h23: return I_LW;
      6'h2b: return I_SW;
      6'h04: return I_BEQ;
      6'h02: return I_J;
      6'h03: return I_JAL;
      default: return I_BAD;
    endcase
  endfunction

  function automatic bit reads(in_t v, logic [4:0] r);
    ins_e i = classify(v);
    bit use_rs = i inside {I_ADDU, I_SUBU, I_ORI, I_LW, I_SW, I_BEQ, I_JR};
    bit use_rt = i inside {I_ADDU, I_SUBU, I_SW, I_BEQ};
    return (use_rs && v.rs == r) || (use_rt && v.rt == r);
  endfunction

  function automatic mw_t word(in_t v);
    mw_t w = '0;
    ins_e i = classify(v);
    logic [4:0] d;
    case (i)
      I_ORI, I_LUI, I_LW: d = v.rt;
      I_JAL:              d = 5'd31;
      I_ADDU, I_SUBU:     d = v.rd;
      default:            d = 5'd0;
    endcase
    w.a3    = d;
    w.regwr = (i inside {I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_JAL}) && d != 5'd0;
    w.memrd = (i == I_LW);
    w.memwr = (i == I_SW);
    w.alu   = (i == I_SUBU || i == I_BEQ) ? 2'd1 : (i == I_ORI) ? 2'd2 :
              (i == I_LUI) ? 2'd3 : 2'd0;
    return w;
  endfunction

  function automatic bit exp_stall();
    bit br = classify(cur) inside {I_BEQ, I_JR};
    if (!rst_n || !cur.v) return 1'b0;
    return (hist[0].memrd && hist[0].a3 != 5'd0 && reads(cur, hist[0].a3)) ||
           (br && hist[0].regwr && reads(cur, hist[0].a3)) ||
           (br && hist[1].memrd && reads(cur, hist[1].a3));
  endfunction

  function automatic logic [1:0] exp_pc();
    ins_e i = classify(cur);
    if (!rst_n || !cur.v || exp_stall()) return 2'd0;
    if ((i == I_BEQ && cur.z) || i == I_J || i == I_JAL) return 2'd1;
    if (i == I_JR) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [2:0] exp_npc();
    ins_e i = classify(cur);
    if (!rst_n || !cur.v || exp_stall()) return 3'd0;
    case (i)
      I_BEQ: return 3'd1;
      I_JAL: return 3'd2;
      I_JR:  return 3'd3;
      I_J:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_all();
    logic [4:0]  rw, mr, mw;
    logic [24:0] a3v;
    logic        ext;
    for (int k = 0; k < 5; k++) begin
      rw[k] = hist[k].regwr; mr[k] = hist[k].memrd; mw[k] = hist[k].memwr;
      a3v[5*k +: 5] = hist[k].a3;
    end
    ext = rst_n && cur.v && (classify(cur) inside {I_LW, I_SW});
    chk("stall0", bus0.stall, exp_stall());  chk("stall1", bus1.stall, exp_stall());
    chk("pc0", bus0.pc_sel, exp_pc());       chk("pc1", bus1.pc_sel, exp_pc());
    chk("npc0", bus0.npc_sel, exp_npc());    chk("npc1", bus1.npc_sel, exp_npc());
    chk("ext0", bus0.ext_op, ext);           chk("ext1", bus1.ext_op, ext);
    chk("flush0", bus0.flush_f, 1'b0);       chk("flush1", bus1.flush_f, exp_pc() != 2'd0);
    chk("ill0", bus0.illegal, ill_exp);      chk("ill1", bus1.illegal, ill_exp);
    chk("alu0", bus0.alu_op_e, hist[0].alu); chk("alu1", bus1.alu_op_e, hist[0].alu);
    chk("regwr0", bus0.regwr, rw[2:0]);      chk("regwr1", bus1.regwr, rw);
    chk("a3_0", bus0.a3, a3v[14:0]);         chk("a3_1", bus1.a3, a3v);
    chk("memrd0", bus0.memrd, mr[2:0]);      chk("memrd1", bus1.memrd, mr);
    chk("memwr0", bus0.memwr, mw[2:0]);      chk("memwr1", bus1.memwr, mw);
  endtask

  task automatic drive(in_t v);
    cur = v;
    bus0.d_valid = v.v; bus0.op = v.op; bus0.func = v.func;
    bus0.rs = v.rs; bus0.rt = v.rt; bus0.rd = v.rd; bus0.zero = v.z;
    bus1.d_valid = v.v; bus1.op = v.op; bus1.func = v.func;
    bus1.rs = v.rs; bus1.rt = v.rt; bus1.rd = v.rd; bus1.zero = v.z;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 5; k++) hist[k] = '0;
    ill_exp = 1'b0;
    last_st = 1'b0;
  endtask

  task automatic advance();
    bit st;
    if (!rst_n) begin
      clear_model();
      return;
    end
    st = exp_stall();
    for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = (cur.v && !st) ? word(cur) : '0;
    ill_exp = cur.v && classify(cur) == I_BAD;
    last_st = st;
  endtask

  task automatic pre(in_t v);
    @(negedge clk);
    drive(v);
    #1;
    check_all();
  endtask

  task automatic post();
    @(posedge clk);
    advance();
  endtask

  task automatic step(in_t v);
    pre(v);
    post();
  endtask

  initial begin
    in_t nop;
    nop = mk(0, 6'h00, 6'h00, 0, 0, 0, 0);
    clear_model();
    drive(nop);

    // Sequence: load-use, branch-on-ALU, jal, illegal, jr-on-load-in-M.
    tab[0]  = tv(mk(1, 6'h23, 6'h00, 1, 5, 0, 0), 0, 0, 0, 0, 0, 0, 0);
    tab[1]  = tv(mk(1, 6'h00, 6'h21, 5, 7, 6, 0), 1, 0, 0, 0, 5, 1, 0);
    tab[2]  = tv(mk(1, 6'h00, 6'h21, 5, 7, 6, 0), 0, 0, 0, 0, 0, 0, 0);
    tab[3]  = tv(mk(1, 6'h0d, 6'h00, 0, 3, 0, 0), 0, 0, 0, 0, 6, 1, 0);
    tab[4]  = tv(mk(1, 6'h04, 6'h00, 3, 0, 0, 1), 1, 0, 0, 0, 3, 1, 0);
    tab[5]  = tv(mk(1, 6'h04, 6'h00, 3, 0, 0, 1), 0, 1, 1, 1, 0, 0, 0);
    tab[6]  = tv(mk(1, 6'h03, 6'h00, 0, 0, 0, 0), 0, 1, 2, 1, 0, 0, 0);
    tab[7]  = tv(mk(1, 6'h3f, 6'h00, 0, 0, 0, 0), 0, 0, 0, 0, 31, 1, 0);
    tab[8]  = tv(mk(0, 6'h04, 6'h00, 31, 31, 0, 1), 0, 0, 0, 0, 0, 0, 1);
    tab[9]  = tv(nop, 0, 0, 0, 0, 0, 0, 0);
    tab[10] = tv(mk(1, 6'h23, 6'h00, 0, 4, 0, 0), 0, 0, 0, 0, 0, 0, 0);
    tab[11] = tv(mk(1, 6'h00, 6'h21, 1, 2, 8, 0), 0, 0, 0, 0, 4, 1, 0);
    tab[12] = tv(mk(1, 6'h00, 6'h08, 4, 0, 0, 0), 1, 0, 0, 0, 8, 1, 0);
    tab[13] = tv(mk(1, 6'h00, 6'h08, 4, 0, 0, 0), 0, 2, 3, 1, 0, 0, 0);
    tab[14] = tv(nop, 0, 0, 0, 0, 0, 0, 0);

    // Reset state, including a taken jump presented while held in reset.
    #3;
    check_all();
    drive(mk(1, 6'h03, 6'h00, 0, 0, 0, 0));
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(nop);
    post();
    step(nop);

    for (int n = 0; n < 15; n++) begin
      pre(tab[n].i);
      chk($sformatf("t%0d.stall", n), bus0.stall, tab[n].st);
      chk($sformatf("t%0d.pc", n), bus0.pc_sel, tab[n].pc);
      chk($sformatf("t%0d.npc", n), bus0.npc_sel, tab[n].npc);
      chk($sformatf("t%0d.flush1", n), bus1.flush_f, tab[n].fl1);
      chk($sformatf("t%0d.e_a3", n), bus0.a3[4:0], tab[n].ea3);
      chk($sformatf("t%0d.e_regwr", n), bus0.regwr[0], tab[n].ewr);
      chk($sformatf("t%0d.illegal", n), bus0.illegal, tab[n].ill);
      post();
    end

    // Random traffic on a small register file so hazards are frequent;
    // a stalled instruction is re-presented the way a held F/D would.
    for (int n = 0; n < 300; n++) begin
      in_t r;
      int  pick;
      pick   = $urandom_range(0, 10);
      r.v    = ($urandom_range(0, 9) != 0);
      r.rs   = 5'($urandom_range(0, 7));
      r.rt   = 5'($urandom_range(0, 7));
      r.rd   = 5'($urandom_range(0, 7));
      r.z    = 1'($urandom_range(0, 1));
      r.func = 6'($urandom_range(0, 63));
      case (pick)
        0: begin r.op = 6'h00; r.func = 6'h21; end
        1: begin r.op = 6'h00; r.func = 6'h23; end
        2: begin r.op = 6'h00; r.func = 6'h08; end
        3: r.op = 6'h0d;
        4: r.op = 6'h0f;
        5: r.op = 6'h23;
        6: r.op = 6'h2b;
        7: r.op = 6'h04;
        8: r.op = 6'h02;
        9: r.op = 6'h03;
        default: r.op = 6'($urandom_range(0, 63));
      endcase
      if (last_st) r = cur;
      step(r);
    end

    // Asynchronous reset with a load sitting in M and a dependent beq in D.
    step(nop);
    step(nop);
    step(mk(1, 6'h23, 6'h00, 0, 2, 0, 0));
    step(nop);
    pre(mk(1, 6'h04, 6'h00, 2, 2, 0, 1));
    chk("mid.stall_before_rst", bus0.stall, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    clear_model();
    check_all();
    chk("mid.memrd_m", bus1.memrd[1], 1'b0);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1, 6'h00, 6'h21, 1, 1, 9, 0));
    #1;
    check_all();
    chk("rel.stall", bus0.stall, 1'b0);
    post();
    repeat (4) step(nop);
    pre(nop);
    chk("s5.a3_stage4", bus1.a3[24:20], 5'd9);
    post();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of registered control stages after D (index 0 = E, 1 = M, 2 = W, ...); legal range 3..8.
REQ-002 SHALL have parameter DELAY_SLOT, default 1; 1 = branch delay slot executes, 0 = taken transfer flushes F.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- d_valid  in  1  D holds a real instruction.
- op  in  6  IR[31:26] at D.
- func  in  6  IR[5:0] at D.
- rs  in  5  IR[25:21] at D.
- rt  in  5  IR[20:16] at D.
- rd  in  5  IR[15:11] at D.
- zero  in  1  D-stage equality compare.
- stall  out  1  hold PC and the F/D register.
- flush_f  out  1  kill the instruction in F.
- pc_sel  out  2  00 ADD4, 01 NPC, 10 RD1.
- npc_sel  out  3  000 none, 001 BEQ, 010 JAL, 011 JR, 100 J.
- ext_op  out  1  1 = sign extend, 0 = zero extend.
- alu_op_e  out  2  00 add, 01 sub, 10 or, 11 lui.
- regwr  out  STAGES  per-stage write enable.
- a3  out  5*STAGES  per-stage destination register, stage k at bits [5k+4:5k].
- memrd  out  STAGES  per-stage lw flag.
- memwr  out  STAGES  per-stage sw flag.
- illegal  out  1  one-cycle pulse for an undecodable valid instruction.

Function
REQ-004 SHALL decode R-type (op 0) addu 0x21, subu 0x23, jr 0x08; ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, j 0x02, jal 0x03.
REQ-005 SHALL select the destination: rt for ori, lui and lw; 31 for jal; rd for addu and subu; 0 otherwise.
REQ-006 SHALL force regwr to 0 whenever the destination is 0.
REQ-007 SHALL drive ext_op = lw|sw combinationally from D.
REQ-008 SHALL drive npc_sel combinationally from D per the REQ-003 encoding.
REQ-009 SHALL drive pc_sel = NPC for (beq&zero)|j|jal, RD1 for jr, ADD4 otherwise.
REQ-010 SHALL force pc_sel = ADD4 and npc_sel = 0 while stall=1.
REQ-011 SHALL assert stall (load-use) when stage E has memrd=1 with a3 nonzero and equal to a source D reads: rs for addu, subu, ori, lw, sw, beq, jr; rt for addu, subu, sw, beq.
REQ-012 SHALL assert stall (branch) when D is beq or jr and stage E has regwr=1 with a3 equal to a source it reads.
REQ-013 SHALL assert stall (branch) when D is beq or jr and stage M has memrd=1 with a3 equal to a source it reads.
REQ-014 SHALL, each cycle stall=1, load an all-zero bubble into stage E while D holds; stall is combinational, no extra latency.
REQ-015 SHALL advance stage k to stage k+1 every cycle; stage STAGES-1 is discarded; stages at and beyond E never stall.
REQ-016 SHALL load E with the D control word one cycle after acceptance (d_valid=1, stall=0).
REQ-017 SHALL, with DELAY_SLOT=0, pulse flush_f for the cycle a taken transfer is accepted; flush_f is always 0 with DELAY_SLOT=1.
REQ-018 SHALL give stall priority over flush_f in the same cycle: flush_f=0 while stall=1, and asserts only once the branch is accepted.
REQ-019 SHALL decode an unknown op/func with d_valid=1 as a bubble and pulse illegal one cycle later, registered.
REQ-020 SHALL treat d_valid=0 as a bubble: no stall, no flush_f, no illegal.

Reset
REQ-021 SHALL, on rst_n low, clear all stage registers, regwr, a3, memrd, memwr, alu_op_e and illegal to 0 immediately, including mid-operation.
REQ-022 SHALL hold stall, flush_f, pc_sel and npc_sel at 0 while rst_n=0.
REQ-023 SHALL decode normally on the first clock edge after rst_n rises.

Structure
REQ-024 SHALL place opcode/func constants, pc_sel/npc_sel/alu_op encodings and the control-word field layout in the shared header package.
REQ-025 SHALL isolate the combinational op/func-to-control-word decoder in one sub-module, ctrl_decode; hazard logic and the stage shift register stay in ctrl_pipe.

Verification
REQ-026 Load-use: lw $5 then addu $6,$5,$7 -> stall=1 one cycle, regwr[0]=0 in the bubble, addu reaches E next cycle with a3[4:0]=6.
REQ-027 Branch hazard: ori $3 then beq $3,$0 with zero=1 -> stall=1 one cycle, then pc_sel=01, npc_sel=001.
REQ-028 jal with DELAY_SLOT=0 -> pc_sel=01, npc_sel=010, flush_f=1 one cycle; a3 reaches 31 in stage E the next cycle, then stage M, then stage W.
REQ-029 Illegal op 0x3f, d_valid=1 -> illegal=1 next cycle, regwr, memrd and memwr all 0 through every stage.
REQ-030 rst_n low mid-stream with lw in stage M -> all stage outputs 0 immediately, no stall after release; STAGES=5 run shows a3 reaching stage 4 at cycle 5.
